avalon_rr_arbiter: RTL

//  Shares one Avalon-MM slave (30-bit word address, 32-bit data, byte enables, waitrequest,

---
 rtl/avalon_rr_arbiter_if.sv | 27 ++
 rtl/avalon_rr_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/avalon_rr_arbiter_if.sv
// One Avalon-MM link: word address, byte enables, read/write strobes,
// write data, zero-latency read data and waitrequest.
interface avalon_rr_arbiter_if;
  localparam int unsigned ADDR_W = 30;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  logic [ADDR_W-1:0] addr;
  logic [BE_W-1:0]   byte_en;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              wait_request;

  // Side that issues transfers
  modport master (
    output addr, byte_en, read, write, write_data,
    input  read_data, wait_request
  );

  // Side that answers transfers
  modport slave (
    input  addr, byte_en, read, write, write_data,
    output read_data, wait_request
  );
endinterface

// File: rtl/avalon_rr_arbiter.sv
// Two-master round-robin arbiter in front of one Avalon-MM slave.
// A grant is held for a whole transfer; an optional watchdog aborts
// transfers that the slave stalls for too long.
module avalon_rr_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ABORT_DATA     = 32'hDEADBEEF
) (
  input  logic                i_Clk,
  input  logic                i_Rst_n,
  avalon_rr_arbiter_if.slave  m0,
  avalon_rr_arbiter_if.slave  m1,
  avalon_rr_arbiter_if.master s,
  output logic                o_Timeout
);

  // Wide enough to hold TIMEOUT_CYCLES-1, the last compared value
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GRANT0 = 3'd1,
    GRANT1 = 3'd2,
    ABORT0 = 3'd3,
    ABORT1 = 3'd4
  } state_t;

  state_t           state;
  logic             last;
  logic [CNT_W-1:0] stall_cnt;

  logic req0;
  logic req1;
  logic cur_id;
  logic cur_req;
  logic oth_req;

  // Request decode and view of the currently granted master
  assign req0    = m0.read | m0.write;
  assign req1    = m1.read | m1.write;
  assign cur_id  = (state == GRANT1);
  assign cur_req = cur_id ? req1 : req0;
  assign oth_req = cur_id ? req0 : req1;

  // Arbitration state, last-served master and stall watchdog
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state     <= IDLE;
      last      <= 1'b1;
      stall_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          stall_cnt <= '0;
          if (req0 && (!req1 || last)) begin
            state <= GRANT0;
          end else if (req1) begin
            state <= GRANT1;
          end
        end

        GRANT0, GRANT1: begin
          if (!cur_req) begin
            // Master withdrew before the slave accepted: nothing transferred
            state     <= IDLE;
            stall_cnt <= '0;
          end else if (!s.wait_request) begin
            last      <= cur_id;
            stall_cnt <= '0;
            if (oth_req) begin
              state <= cur_id ? GRANT0 : GRANT1;
            end
          end else begin
            stall_cnt <= stall_cnt + CNT_W'(1);
            if ((TIMEOUT_CYCLES != 0) && (stall_cnt == CNT_LAST)) begin
              state <= cur_id ? ABORT1 : ABORT0;
            end
          end
        end

        ABORT0: begin
          last      <= 1'b0;
          stall_cnt <= '0;
          state     <= IDLE;
        end

        ABORT1: begin
          last      <= 1'b1;
          stall_cnt <= '0;
          state     <= IDLE;
        end

        default: begin
          stall_cnt <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Bus steering: slave follows the granted master, the other master stalls
  always_comb begin
    s.addr          = '0;
    s.byte_en       = '0;
    s.read          = 1'b0;
    s.write         = 1'b0;
    s.write_data    = '0;
    m0.wait_request = 1'b1;
    m1.wait_request = 1'b1;
    m0.read_data    = '0;
    m1.read_data    = '0;
    o_Timeout       = 1'b0;

    case (state)
      GRANT0: begin
        s.addr          = m0.addr;
        s.byte_en       = m0.byte_en;
        s.read          = m0.read & ~m0.write;
        s.write         = m0.write;
        s.write_data    = m0.write_data;
        m0.wait_request = s.wait_request;
        m0.read_data    = s.read_data;
      end

      GRANT1: begin
        s.addr          = m1.addr;
        s.byte_en       = m1.byte_en;
        s.read          = m1.read & ~m1.write;
        s.write         = m1.write;
        s.write_data    = m1.write_data;
        m1.wait_request = s.wait_request;
        m1.read_data    = s.read_data;
      end

      ABORT0: begin
        m0.wait_request = 1'b0;
        m0.read_data    = ABORT_DATA;
        o_Timeout       = 1'b1;
      end

      ABORT1: begin
        m1.wait_request = 1'b0;
        m1.read_data    = ABORT_DATA;
        o_Timeout       = 1'b1;
      end

      default: begin
      end
    endcase
  end

endmodule
